// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - Fetch, decode and data-memory handshake bundle between sequencer and datapath.
interface cpu_sequencer_if #(
  parameter int PC_W = 16
);
  logic [PC_W-1:0] pc;
  logic [15:0]     instruction;
  logic [15:0]     ir;
  logic            jump;
  logic            branch;
  logic            is_zero;
  logic            regwrite_in;
  logic            memwrite_in;
  logic            memtoreg_in;
  logic            mem_ack;
  logic            regwrite_out;
  logic            memwrite_out;
  logic            mem_req;

  modport master (
    output pc, ir, regwrite_out, memwrite_out, mem_req,
    input  instruction, jump, branch, is_zero, regwrite_in, memwrite_in, memtoreg_in, mem_ack
  );

  modport slave (
    input  pc, ir, regwrite_out, memwrite_out, mem_req,
    output instruction, jump, branch, is_zero, regwrite_in, memwrite_in, memtoreg_in, mem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - Multi-cycle fetch/exec/mem sequencer owning pc and ir for the 16-bit CPU.
// Optional single-step input enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
  parameter int PC_W       = 16,
  parameter int WAIT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step_i,
`endif
  cpu_sequencer_if.master bus,
  output logic        busy_o,
  output logic        halted_o,
  output logic        timeout_err_o,
  output logic [15:0] instr_count_o
);

  localparam int          CNT_W     = $clog2(WAIT_LIMIT + 1);
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [15:0]     count_q, count_d;
  logic            terr_q, terr_d;
  logic            retire;
  logic            start;
  logic            regwrite;
  logic            memwrite;
  logic [PC_W-1:0] next_pc;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q, step_d;

  // Only a fresh rising edge of step starts an instruction, so a held step runs once.
  assign step_d = step_i;
  assign start  = run_en_i | (step_i & ~step_q);
`else
  assign start = run_en_i;
`endif

  always_comb begin
    if (bus.jump) begin
      next_pc = PC_W'(ir_q[12:0]);
    end else if (bus.branch && bus.is_zero) begin
      next_pc = PC_W'(ir_q[6:0]);
    end else begin
      next_pc = pc_q + PC_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    wait_d   = wait_q;
    count_d  = count_q;
    terr_d   = terr_q;
    retire   = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = bus.instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_q == HALT_WORD) begin
          state_d = S_HALT;
        end else if (bus.memtoreg_in || bus.memwrite_in) begin
          state_d = S_MEM;
          wait_d  = CNT_W'(1);
        end else begin
          regwrite = bus.regwrite_in;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          memwrite = bus.memwrite_in;
          regwrite = bus.regwrite_in & bus.memtoreg_in;
          retire   = 1'b1;
        end else if (wait_q == CNT_W'(WAIT_LIMIT)) begin
          terr_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping run_en mid-instruction lets it finish, then parks at the boundary.
    if (retire) begin
      pc_d    = next_pc;
      state_d = run_en_i ? S_FETCH : S_IDLE;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      wait_q  <= '0;
      count_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      terr_q  <= terr_d;
    end
  end

`ifdef SEQ_SINGLE_STEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end
`endif

  // mem_req is decoded from state so an asynchronous reset removes it immediately.
  assign bus.pc           = pc_q;
  assign bus.ir           = ir_q;
  assign bus.mem_req      = (state_q == S_MEM);
  assign bus.regwrite_out = regwrite;
  assign bus.memwrite_out = memwrite;
  assign busy_o           = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted_o         = (state_q == S_HALT);
  assign timeout_err_o    = terr_q;
  assign instr_count_o    = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - Scoreboard bench for cpu_sequencer with a behavioural imem/decode model.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic run_en;
  logic run_en4;
  logic mem_ack;
`ifdef SEQ_SINGLE_STEP_EN
  logic step;
  logic step4;
`endif
  logic        busy, halted, terr;
  logic [15:0] count;
  logic        busy4, halted4, terr4;
  logic [15:0] count4;

  int passed = 0;
  int total  = 0;

  logic [15:0] imem  [0:63];
  logic [15:0] imem4 [0:15];

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [15:0] ir;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] pc_q[$];
  logic [15:0] prev_count;

  cpu_sequencer_if #(.PC_W(16)) bus ();
  cpu_sequencer_if #(.PC_W(4))  bus4 ();

  // Bench decode: opcode ir[15:13]; 0 ADD, 1 LOAD, 2 STORE, 3 BRZ, 4 JMP, 5 JMP+BRZ; is_zero modelled by ir[7].
  function automatic logic [4:0] dec(input logic [15:0] w);
    case (w[15:13])
      3'd0:    dec = 5'b00100;
      3'd1:    dec = 5'b00101;
      3'd2:    dec = 5'b00010;
      3'd3:    dec = 5'b01000;
      3'd4:    dec = 5'b10000;
      3'd5:    dec = 5'b11000;
      default: dec = 5'b00000;
    endcase
  endfunction

  always #5 clk = ~clk;

  assign bus.instruction = imem[bus.pc[5:0]];
  assign {bus.jump, bus.branch, bus.regwrite_in, bus.memwrite_in, bus.memtoreg_in} = dec(bus.ir);
  assign bus.is_zero = bus.ir[7];
  assign bus.mem_ack = mem_ack;

  assign bus4.instruction = imem4[bus4.pc];
  assign {bus4.jump, bus4.branch, bus4.regwrite_in, bus4.memwrite_in, bus4.memtoreg_in} = dec(bus4.ir);
  assign bus4.is_zero = bus4.ir[7];
  assign bus4.mem_ack = 1'b0;

  cpu_sequencer #(.PC_W(16), .WAIT_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .run_en_i     (run_en),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i       (step),
`endif
    .bus          (bus.master),
    .busy_o       (busy),
    .halted_o     (halted),
    .timeout_err_o(terr),
    .instr_count_o(count)
  );

  cpu_sequencer #(.PC_W(4), .WAIT_LIMIT(8)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .run_en_i     (run_en4),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i       (step4),
`endif
    .bus          (bus4.master),
    .busy_o       (busy4),
    .halted_o     (halted4),
    .timeout_err_o(terr4),
    .instr_count_o(count4)
  );

  // Scoreboard: every write pulse and every retirement is matched against the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_count = 16'd0;
    end else begin
      if (bus.regwrite_out || bus.memwrite_out) begin
        total++;
        if (wr_q.size() == 0) begin
          $display("FAIL sb_write unexpected rw=%0b mw=%0b ir=%h", bus.regwrite_out, bus.memwrite_out, bus.ir);
        end else begin
          wr_t e;
          wr_t got;
          e   = wr_q.pop_front();
          got = '{rw: bus.regwrite_out, mw: bus.memwrite_out, ir: bus.ir};
          if (got !== e) $display("FAIL sb_write got=%h expected=%h", got, e);
          else passed++;
        end
      end
      if (count !== prev_count) begin
        total++;
        if (pc_q.size() == 0) begin
          $display("FAIL sb_retire unexpected pc=%h count=%0d", bus.pc, count);
        end else begin
          logic [15:0] ep;
          ep = pc_q.pop_front();
          if (bus.pc !== ep) $display("FAIL sb_retire pc=%h expected=%h", bus.pc, ep);
          else passed++;
        end
        prev_count = count;
      end
    end
  end

  task automatic load_prog();
    for (int i = 0; i < 64; i++) imem[i] = 16'hFFFF;
    for (int i = 0; i < 16; i++) imem4[i] = 16'hFFFF;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    run_en  = 1'b0;
    run_en4 = 1'b0;
    mem_ack = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step    = 1'b0;
    step4   = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_prog();
    rst     = 1'b1;
    run_en  = 1'b1;
    run_en4 = 1'b1;
    mem_ack = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    step    = 1'b0;
    step4   = 1'b0;
`endif
    #3;
    total++;
    if ({bus.pc, bus.ir, count} !== 48'd0) $display("FAIL reset_regs pc=%h ir=%h count=%0d expected 0", bus.pc, bus.ir, count);
    else passed++;
    total++;
    if ({busy, halted, terr, bus.mem_req, bus.regwrite_out, bus.memwrite_out} !== 6'd0)
      $display("FAIL reset_status got=%b expected 000000", {busy, halted, terr, bus.mem_req, bus.regwrite_out, bus.memwrite_out});
    else passed++;
    total++;
    if (bus4.pc !== 4'd0) $display("FAIL reset_pc4 pc=%h expected 0", bus4.pc);
    else passed++;
    do_reset();
  endtask

  task automatic test_basic_run();
    load_prog();
    imem[0] = 16'h0011;
    imem[1] = 16'h0022;
    do_reset();
    wr_q.push_back('{rw: 1'b1, mw: 1'b0, ir: 16'h0011});
    wr_q.push_back('{rw: 1'b1, mw: 1'b0, ir: 16'h0022});
    pc_q.push_back(16'd1);
    pc_q.push_back(16'd2);
    run_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (halted !== 1'b0) $display("FAIL basic_halt_early halted=%b expected 0 at cycle 6", halted);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({halted, busy, count, bus.pc} !== {1'b1, 1'b0, 16'd2, 16'd2})
      $display("FAIL basic_halt halted=%b busy=%b count=%0d pc=%h expected 1 0 2 0002", halted, busy, count, bus.pc);
    else passed++;
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    total++;
    if ({halted, count, bus.pc} !== {1'b1, 16'd2, 16'd2})
      $display("FAIL halt_absorbing halted=%b count=%0d pc=%h expected 1 2 0002", halted, count, bus.pc);
    else passed++;
    total++;
    if (wr_q.size() + pc_q.size() != 0) $display("FAIL basic_drain left=%0d expected 0", wr_q.size() + pc_q.size());
    else passed++;
  endtask

  task automatic test_load_ack();
    int memcyc;
    load_prog();
    imem[0] = 16'h0001;
    imem[1] = 16'h0002;
    imem[2] = 16'h0003;
    imem[3] = 16'h2033;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_q.push_back('{rw: 1'b1, mw: 1'b0, ir: 16'(i + 1)});
      pc_q.push_back(16'(i + 1));
    end
    wr_q.push_back('{rw: 1'b1, mw: 1'b0, ir: 16'h2033});
    pc_q.push_back(16'd4);
    run_en = 1'b1;
    memcyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (bus.mem_req) begin
        memcyc++;
        if (memcyc == 3) mem_ack = 1'b1;
      end else if (memcyc > 0) begin
        break;
      end
    end
    total++;
    if (memcyc !== 3) $display("FAIL load_req_cycles got=%0d expected 3", memcyc);
    else passed++;
    total++;
    if ({bus.pc, count} !== {16'd4, 16'd4}) $display("FAIL load_pc pc=%h count=%0d expected 0004 4", bus.pc, count);
    else passed++;
    for (int i = 0; i < 10 && !halted; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if ({halted, terr} !== 2'b10) $display("FAIL load_halt halted=%b terr=%b expected 1 0", halted, terr);
    else passed++;
    total++;
    if (wr_q.size() + pc_q.size() != 0) $display("FAIL load_drain left=%0d expected 0", wr_q.size() + pc_q.size());
    else passed++;
  endtask

  task automatic test_store_timeout();
    int   memcyc;
    logic saw_mw;
    load_prog();
    imem[0] = 16'h4055;
    imem[1] = 16'h0001;
    do_reset();
    run_en = 1'b1;
    memcyc = 0;
    saw_mw = 1'b0;
    for (int i = 0; i < 40 && !halted; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req) memcyc++;
      if (bus.memwrite_out) saw_mw = 1'b1;
    end
    total++;
    if (memcyc !== 8) $display("FAIL timeout_cycles got=%0d expected 8", memcyc);
    else passed++;
    total++;
    if ({terr, halted, saw_mw} !== 3'b110) $display("FAIL timeout_flags terr=%b halted=%b mw_seen=%b expected 1 1 0", terr, halted, saw_mw);
    else passed++;
    total++;
    if ({count, bus.pc} !== 32'd0) $display("FAIL timeout_no_retire count=%0d pc=%h expected 0 0000", count, bus.pc);
    else passed++;
  endtask

  task automatic test_branch_jump();
    load_prog();
    imem[0]  = 16'h60A8;
    imem[40] = 16'h6007;
    imem[41] = 16'h9FFF;
    imem[63] = 16'hA085;
    do_reset();
    pc_q.push_back(16'd40);
    pc_q.push_back(16'd41);
    pc_q.push_back(16'h1FFF);
    pc_q.push_back(16'h0085);
    run_en = 1'b1;
    for (int i = 0; i < 40 && !halted; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if ({halted, count, bus.pc} !== {1'b1, 16'd4, 16'h0085})
      $display("FAIL branch_final halted=%b count=%0d pc=%h expected 1 4 0085", halted, count, bus.pc);
    else passed++;
    total++;
    if (pc_q.size() != 0) $display("FAIL branch_drain left=%0d expected 0", pc_q.size());
    else passed++;
  endtask

  task automatic test_pc_wrap();
    load_prog();
    imem4[0]  = 16'h800F;
    imem4[15] = 16'h0007;
    do_reset();
    run_en4 = 1'b1;
    for (int i = 0; i < 20 && count4 != 16'd1; i++) begin
      @(posedge clk);
      #1;
    end
    run_en4 = 1'b0;
    total++;
    if ({count4, bus4.pc} !== {16'd1, 4'hF}) $display("FAIL wrap_jump count=%0d pc=%h expected 1 f", count4, bus4.pc);
    else passed++;
    for (int i = 0; i < 20 && !(count4 == 16'd2 && !busy4); i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if ({count4, bus4.pc, busy4, halted4} !== {16'd2, 4'h0, 1'b0, 1'b0})
      $display("FAIL wrap_stop count=%0d pc=%h busy=%b halted=%b expected 2 0 0 0", count4, bus4.pc, busy4, halted4);
    else passed++;
  endtask

  task automatic test_reset_mid_mem();
    load_prog();
    imem[0] = 16'h0044;
    imem[1] = 16'h2001;
    do_reset();
    wr_q.push_back('{rw: 1'b1, mw: 1'b0, ir: 16'h0044});
    pc_q.push_back(16'd1);
    run_en = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_req; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if ({bus.mem_req, bus.pc} !== {1'b1, 16'd1}) $display("FAIL rstmem_setup mem_req=%b pc=%h expected 1 0001", bus.mem_req, bus.pc);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.mem_req, busy, halted} !== 3'b000) $display("FAIL rstmem_req mem_req=%b busy=%b halted=%b expected 0 0 0", bus.mem_req, busy, halted);
    else passed++;
    total++;
    if ({bus.pc, count} !== 32'd0) $display("FAIL rstmem_regs pc=%h count=%0d expected 0 0", bus.pc, count);
    else passed++;
    do_reset();
    total++;
    if (wr_q.size() + pc_q.size() != 0) $display("FAIL rstmem_drain left=%0d expected 0", wr_q.size() + pc_q.size());
    else passed++;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    load_prog();
    for (int i = 0; i < 4; i++) begin
      imem[i] = 16'(16'h0050 + i);
      wr_q.push_back('{rw: 1'b1, mw: 1'b0, ir: 16'(16'h0050 + i)});
      pc_q.push_back(16'(i + 1));
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (!busy) break;
      end
      total++;
      if ({count, busy} !== {16'(k + 1), 1'b0}) $display("FAIL step_%0d count=%0d busy=%b expected %0d 0", k, count, busy, k + 1);
      else passed++;
    end
    step = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    step = 1'b0;
    total++;
    if ({count, busy, halted} !== {16'd4, 1'b0, 1'b0}) $display("FAIL step_held count=%0d busy=%b halted=%b expected 4 0 0", count, busy, halted);
    else passed++;
  endtask
`endif

  initial begin
    load_prog();
    prev_count = 16'd0;
    test_reset();
    test_basic_run();
    test_load_ack();
    test_store_timeout();
    test_branch_jump();
    test_pc_wrap();
    test_reset_mid_mem();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
